// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Fetch-stage controller. Owns the architectural PC and drives the shared PC
//   adder (base + offset). It issues fetch requests over a valid/ready
//   handshake. Each cycle it picks one of: sequential advance, a
//   branch/JAL/JALR redirect, or trap entry. Events that arrive while a request
//   is waiting to be accepted are held until the handshake.
//
// Ports
//   i_clock, i_reset        clock; synchronous active-high reset
//   i_stall                 blocks issuing new fetches (ignored while holding)
//   i_redirect*             redirect request and its operands from execute
//   i_trap                  trap entry request, overrides redirect
//   o_alu*, i_aluResult     operands to / sum from the shared PC adder
//   o_fetchValid/Addr,
//   i_fetchReady            instruction memory request handshake
//   o_misaligned            one-cycle pulse for a dropped misaligned redirect
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic        i_redirectJalr,
    input  logic [31:0] i_redirectPc,
    input  logic [31:0] i_redirectImm,
    input  logic [31:0] i_redirectReg,
    input  logic        i_trap,
    output logic [1:0]  o_aluOp,
    output logic [31:0] o_aluPc,
    output logic [31:0] o_aluImm,
    output logic [31:0] o_aluReg,
    input  logic [31:0] i_aluResult,
    output logic        o_fetchValid,
    output logic [31:0] o_fetchAddr,
    input  logic        i_fetchReady,
    output logic        o_misaligned
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic [31:0] r_pc;
    logic [31:0] r_pendPc;
    logic        r_pendValid;
    logic        r_pendTrap;
    logic        r_misaligned;

    logic [31:0] w_pcNext;
    logic [31:0] w_pendPcNext;
    logic        w_pendValidNext;
    logic        w_pendTrapNext;

    logic [31:0] w_target;
    logic [31:0] w_pcPlus4;
    logic [31:0] w_seqPc;
    logic        w_active;
    logic        w_trapEv;
    logic        w_redirEv;
    logic        w_misaligned;
    logic        w_handshake;

    // PC adder drive: redirect operands when redirecting, otherwise PC + 4.
    always_comb begin
        if (i_redirect) begin
            o_aluOp = {i_redirectJalr, 1'b1};
            o_aluPc = i_redirectPc;
        end else begin
            o_aluOp = 2'b00;
            o_aluPc = r_pc;
        end
    end

    assign o_aluImm     = i_redirectImm;
    assign o_aluReg     = i_redirectReg;
    assign o_fetchAddr  = r_pc;
    assign o_misaligned = r_misaligned;

    // JALR rule: bit 0 of the sum is always cleared.
    assign w_target    = i_aluResult & ~32'd1;
    assign w_active    = (r_state != S_BOOT);
    assign w_trapEv    = w_active & i_trap;
    assign w_redirEv   = w_active & i_redirect & ~i_trap & ~w_target[1];
    assign w_misaligned = w_active & i_redirect & ~i_trap & w_target[1];
    assign w_handshake = o_fetchValid & i_fetchReady;

    // When the shared adder is busy with a dropped (misaligned) redirect, the
    // sequential PC + 4 still has to be available for a same-cycle handshake,
    // so a private incrementer covers that one case.
    assign w_pcPlus4 = r_pc + 32'd4;
    assign w_seqPc   = i_redirect ? w_pcPlus4 : i_aluResult;

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= S_BOOT;
            r_pc         <= RESET_VECTOR;
            r_pendValid  <= 1'b0;
            r_pendTrap   <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_pc         <= w_pcNext;
            r_pendValid  <= w_pendValidNext;
            r_pendTrap   <= w_pendTrapNext;
            r_misaligned <= w_misaligned;
        end
    end

    // Pending target is qualified by r_pendValid, so it needs no reset.
    always_ff @(posedge i_clock) begin
        r_pendPc <= w_pendPcNext;
    end

    // Next-state logic
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_BOOT: w_stateNext = S_RUN;
            S_RUN: begin
                // A redirected request is replaced, not held.
                if (!w_trapEv && !w_redirEv && o_fetchValid && !i_fetchReady)
                    w_stateNext = S_HOLD;
            end
            S_HOLD: begin
                if (w_handshake)
                    w_stateNext = S_RUN;
            end
            default: w_stateNext = S_BOOT;
        endcase
    end

    // Output logic
    always_comb begin
        case (r_state)
            S_RUN:   o_fetchValid = ~i_stall;
            S_HOLD:  o_fetchValid = 1'b1;
            default: o_fetchValid = 1'b0;
        endcase
    end

    // PC and pending-event update
    always_comb begin
        w_pcNext        = r_pc;
        w_pendPcNext    = r_pendPc;
        w_pendValidNext = r_pendValid;
        w_pendTrapNext  = r_pendTrap;
        case (r_state)
            S_RUN: begin
                if (w_trapEv)
                    w_pcNext = TRAP_VECTOR;
                else if (w_redirEv)
                    w_pcNext = w_target;
                else if (w_handshake)
                    w_pcNext = w_seqPc;
            end
            S_HOLD: begin
                if (w_handshake) begin
                    w_pendValidNext = 1'b0;
                    w_pendTrapNext  = 1'b0;
                    if (w_trapEv)
                        w_pcNext = TRAP_VECTOR;
                    else if (w_redirEv)
                        w_pcNext = w_target;
                    else if (r_pendValid)
                        w_pcNext = r_pendPc;
                    else
                        w_pcNext = w_seqPc;
                end else if (w_trapEv) begin
                    w_pendValidNext = 1'b1;
                    w_pendTrapNext  = 1'b1;
                    w_pendPcNext    = TRAP_VECTOR;
                end else if (w_redirEv && !(r_pendValid && r_pendTrap)) begin
                    // A pending trap is never displaced by a later redirect.
                    w_pendValidNext = 1'b1;
                    w_pendTrapNext  = 1'b0;
                    w_pendPcNext    = w_target;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redir;
    logic        jalr;
    logic [31:0] rpc;
    logic [31:0] imm;
    logic [31:0] rreg;
    logic        trap;
    logic [1:0]  alu_op;
    logic [31:0] alu_pc;
    logic [31:0] alu_imm;
    logic [31:0] alu_reg;
    logic [31:0] alu_res;
    logic        f_valid;
    logic [31:0] f_addr;
    logic        f_ready;
    logic        mis;

    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_stall        (stall),
        .i_redirect     (redir),
        .i_redirectJalr (jalr),
        .i_redirectPc   (rpc),
        .i_redirectImm  (imm),
        .i_redirectReg  (rreg),
        .i_trap         (trap),
        .o_aluOp        (alu_op),
        .o_aluPc        (alu_pc),
        .o_aluImm       (alu_imm),
        .o_aluReg       (alu_reg),
        .i_aluResult    (alu_res),
        .o_fetchValid   (f_valid),
        .o_fetchAddr    (f_addr),
        .i_fetchReady   (f_ready),
        .o_misaligned   (mis)
    );

    // The shared PC adder that sits outside the sequencer.
    assign alu_res = (alu_op[1] ? alu_reg : alu_pc) + (alu_op[0] ? alu_imm : 32'd4);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stall, redir, jalr;
        logic [31:0] rpc, imm, rreg;
        logic        trap, rdy, chk;
        logic        e_valid;
        logic [31:0] e_addr;
        logic [1:0]  e_op;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic rd, input logic j,
                       input logic [31:0] p, input logic [31:0] im, input logic [31:0] rg,
                       input logic t, input logic rdy, input logic chk,
                       input logic ev, input logic [31:0] ea, input logic [1:0] eo,
                       input logic em);
        vec_t v;
        v.rst = r; v.stall = s; v.redir = rd; v.jalr = j;
        v.rpc = p; v.imm = im; v.rreg = rg; v.trap = t; v.rdy = rdy; v.chk = chk;
        v.e_valid = ev; v.e_addr = ea; v.e_op = eo; v.e_mis = em;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic s, input logic rd, input logic j,
                         input logic [31:0] p, input logic [31:0] im, input logic [31:0] rg,
                         input logic t, input logic rdy);
        rst = r; stall = s; redir = rd; jalr = j;
        rpc = p; imm = im; rreg = rg; trap = t; f_ready = rdy;
    endtask

    task automatic check(input string name, input logic ev, input logic [31:0] ea,
                         input logic [1:0] eo, input logic [31:0] ep, input logic chk_pc,
                         input logic em);
        n_checks++;
        if (f_valid !== ev || f_addr !== ea || alu_op !== eo || mis !== em ||
            (chk_pc && alu_pc !== ep)) begin
            n_fail++;
            $display("FAIL %s t=%0t: got valid=%b addr=%h op=%b alupc=%h mis=%b, want valid=%b addr=%h op=%b alupc=%h mis=%b",
                     name, $time, f_valid, f_addr, alu_op, alu_pc, mis,
                     ev, ea, eo, ep, em);
        end
    endtask

    // Reference model state
    logic        m_known, m_boot, m_hold, m_pendV, m_pendTrap, m_mis;
    logic [31:0] m_pc, m_pendPc;

    initial begin
        logic        ev;
        logic        hs, take_trap, take_redir;
        logic [31:0] tgt;
        logic [1:0]  eo;
        logic [31:0] ep;

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // ---------------- directed vectors ----------------
        //   rst st rd j  rpc           imm           reg           tr rdy chk  v  addr          op     mis
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 0,  0, 32'h0,        2'b00, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1,  0, 32'h0,        2'b00, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1,  1, 32'h0,        2'b00, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1,  1, 32'h4,        2'b00, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1,  1, 32'h8,        2'b00, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1,  1, 32'hC,        2'b00, 0);
        add(0, 0, 1, 0, 32'h8,        32'h20,       32'h0,        0, 1, 1,  1, 32'h10,       2'b01, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1,  1, 32'h28,       2'b00, 0);
        add(0, 0, 1, 1, 32'h2C,       32'h3,        32'h1001,     0, 1, 1,  1, 32'h2C,       2'b11, 0);
        add(0, 0, 1, 1, 32'h0,        32'h2,        32'h1000,     0, 1, 1,  1, 32'h1004,     2'b11, 0);
        add(0, 0, 1, 0, 32'h0,        32'h40,       32'h0,        0, 1, 1,  1, 32'h1008,     2'b01, 1);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1,  1, 32'h40,       2'b00, 0);
        add(0, 0, 1, 0, 32'h40,       32'h40,       32'h0,        0, 0, 1,  1, 32'h40,       2'b01, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1,  1, 32'h40,       2'b00, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1,  1, 32'h40,       2'b00, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1,  1, 32'h80,       2'b00, 0);
        add(0, 0, 1, 0, 32'h0,        32'h200,      32'h0,        1, 1, 1,  1, 32'h84,       2'b01, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1,  1, 32'h100,      2'b00, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1,  1, 32'h104,      2'b00, 0);
        add(0, 0, 1, 0, 32'h0,        32'h300,      32'h0,        0, 0, 1,  1, 32'h104,      2'b01, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 0, 1,  1, 32'h104,      2'b00, 0);
        add(0, 0, 1, 0, 32'h0,        32'h400,      32'h0,        0, 0, 1,  1, 32'h104,      2'b01, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1,  1, 32'h104,      2'b00, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1,  1, 32'h100,      2'b00, 0);
        add(0, 1, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1,  0, 32'h104,      2'b00, 0);
        add(0, 1, 1, 0, 32'h0,        32'h500,      32'h0,        0, 1, 1,  0, 32'h104,      2'b01, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1,  1, 32'h500,      2'b00, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1,  1, 32'h504,      2'b00, 0);
        add(0, 0, 1, 0, 32'h0,        32'h600,      32'h0,        0, 0, 1,  1, 32'h504,      2'b01, 0);
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0, 1,  1, 32'h504,      2'b00, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1,  0, 32'h0,        2'b00, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1,  1, 32'h0,        2'b00, 0);
        add(0, 0, 1, 0, 32'h0,        32'hFFFF_FFFC, 32'h0,       0, 1, 1,  1, 32'h4,        2'b01, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1,  1, 32'hFFFF_FFFC, 2'b00, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1,  1, 32'h0,        2'b00, 0);
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1,  1, 32'h4,        2'b00, 0);
        add(0, 0, 1, 0, 32'h0,        32'h700,      32'h0,        1, 1, 1,  0, 32'h0,        2'b01, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1,  1, 32'h0,        2'b00, 0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 1, 1,  1, 32'h4,        2'b00, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].jalr,
                  vecs[i].rpc, vecs[i].imm, vecs[i].rreg, vecs[i].trap, vecs[i].rdy);
            #1;
            if (vecs[i].chk)
                check($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_addr,
                      vecs[i].e_op, 32'h0, 1'b0, vecs[i].e_mis);
        end

        // ---------------- randomized run against the reference model ----------------
        m_known = 1'b0;
        m_boot = 1'b1; m_hold = 1'b0; m_pendV = 1'b0; m_pendTrap = 1'b0; m_mis = 1'b0;
        m_pc = RV; m_pendPc = 32'h0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            drive((c == 0) || ($urandom_range(0, 99) == 0),
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1,
                  $urandom & 32'hFFFF_FFFC,
                  ($urandom & 32'h0000_0FFC) | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0),
                  $urandom & 32'hFFFF_FFFD,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 1) == 1);
            #1;
            ev = !m_boot && (m_hold || !stall);
            eo = redir ? {jalr, 1'b1} : 2'b00;
            ep = redir ? rpc : m_pc;
            if (m_known)
                check("rand", ev, m_pc, eo, ep, 1'b1, m_mis);

            tgt = (jalr ? rreg : rpc) + imm;
            tgt[0] = 1'b0;
            if (rst) begin
                m_known = 1'b1; m_boot = 1'b1; m_hold = 1'b0;
                m_pendV = 1'b0; m_pendTrap = 1'b0; m_mis = 1'b0; m_pc = RV;
            end else if (m_boot) begin
                m_boot = 1'b0; m_mis = 1'b0;
            end else begin
                take_trap  = trap;
                take_redir = redir && !trap && !tgt[1];
                m_mis      = redir && !trap && tgt[1];
                hs         = ev && f_ready;
                if (m_hold) begin
                    if (hs) begin
                        if (take_trap)       m_pc = TV;
                        else if (take_redir) m_pc = tgt;
                        else if (m_pendV)    m_pc = m_pendPc;
                        else                 m_pc = m_pc + 32'd4;
                        m_hold = 1'b0; m_pendV = 1'b0; m_pendTrap = 1'b0;
                    end else if (take_trap) begin
                        m_pendV = 1'b1; m_pendTrap = 1'b1; m_pendPc = TV;
                    end else if (take_redir && !(m_pendV && m_pendTrap)) begin
                        m_pendV = 1'b1; m_pendTrap = 1'b0; m_pendPc = tgt;
                    end
                end else begin
                    if (take_trap)       m_pc = TV;
                    else if (take_redir) m_pc = tgt;
                    else if (hs)         m_pc = m_pc + 32'd4;
                    else if (ev)         m_hold = 1'b1;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage controller that owns the architectural PC register and sequences the shared PC adder (the 2-bit-op PC ALU computing base + offset).
- Issues fetch requests to instruction memory over a valid/ready handshake.
- Chooses each cycle between sequential advance, branch/JAL/JALR redirect and trap entry.
- Holds redirects that arrive while a fetch request is still waiting to be accepted.
- Sits between the execute stage (redirect/trap sources) and the instruction memory port.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap

Ports:
- i_clock  in  1  clock; all state updates on its rising edge
- i_reset  in  1  reset, synchronous, active-high
- i_stall  in  1  pipeline stall; blocks issuing new fetches
- i_redirect  in  1  execute requests PC redirect this cycle
- i_redirectJalr  in  1  1: target = reg + imm; 0: target = pc + imm
- i_redirectPc  in  32  PC of the redirecting instruction
- i_redirectImm  in  32  immediate of the redirecting instruction
- i_redirectReg  in  32  rs1 value (JALR base)
- i_trap  in  1  trap entry request; overrides redirect
- o_aluOp  out  2  to PC ALU: bit1 = base select (pc/reg), bit0 = offset select (4/imm)
- o_aluPc  out  32  to PC ALU pc input
- o_aluImm  out  32  to PC ALU immediate input
- o_aluReg  out  32  to PC ALU register input
- i_aluResult  in  32  PC ALU sum
- o_fetchValid  out  1  fetch request valid
- o_fetchAddr  out  32  fetch address; equals current PC
- i_fetchReady  in  1  memory accepts the request
- o_misaligned  out  1  1-cycle pulse: redirect target not 4-byte aligned

## Operation
- ALU drive, combinational:
  - i_redirect=1: o_aluOp = {i_redirectJalr, 1}, o_aluPc = i_redirectPc.
  - Otherwise: o_aluOp = 2'b00, o_aluPc = PC. Result is PC + 4.
  - o_aluImm and o_aluReg pass i_redirectImm and i_redirectReg through.
- Target = i_aluResult with bit0 cleared (JALR rule).
- A target with bit1 = 1 is misaligned:
  - The redirect is dropped.
  - o_misaligned pulses on the next cycle.
  - PC is unaffected.
- Next-PC priority: trap (TRAP_VECTOR) > aligned redirect (target) > sequential (i_aluResult with op 00, only on handshake).
- Handshake: o_fetchValid & i_fetchReady in the same cycle.
- Pending register: pendValid, pendPc. It captures trap/redirect events that occur in HOLD.
- States:
  - BOOT (reset state)
    - o_fetchValid=0.
    - Unconditionally goes to RUN next cycle.
    - Redirect and trap are ignored.
  - RUN
    - o_fetchValid = !i_stall.
    - On trap/redirect: PC <= that target. Any same-cycle handshake fetch is wrong-path; discarding it is the downstream's job.
    - Else on handshake: PC <= PC+4.
    - Valid with no ready: go to HOLD.
    - Stall: PC held.
  - HOLD
    - o_fetchValid=1 regardless of i_stall.
    - o_fetchAddr held stable.
    - Trap/redirect events are latched into pendPc/pendValid. A later trap overwrites a pending redirect. A later redirect does not overwrite a pending trap.
    - On handshake: PC <= pendValid ? pendPc : PC+4, pendValid <= 0, go to RUN.
    - A trap/redirect in the handshake cycle itself takes priority over the pending value.
- Address arithmetic wraps modulo 2^32. 32'hFFFF_FFFC + 4 = 0; no flag is raised.

## Timing
- Reset values, in the cycle after i_reset is sampled high:
  - PC = o_fetchAddr = RESET_VECTOR.
  - o_fetchValid=0, o_misaligned=0, pendValid=0, state BOOT.
- Reset mid-HOLD abandons the request: valid drops the next cycle and any pending event is lost.
- First request: reset sampled low in cycle N (in BOOT) gives o_fetchValid=1, o_fetchAddr=RESET_VECTOR in cycle N+1.
- Sequential throughput: one fetch per cycle while i_fetchReady=1 and i_stall=0.
- Redirect or trap in RUN, cycle N: o_fetchAddr = target in cycle N+1, with valid if not stalled.
- Redirect in HOLD: applied in the cycle after the handshake.
- Redirect and stall together: PC updated; no fetch until stall deasserts.
- o_misaligned: registered; high exactly one cycle (N+1) per misaligned redirect in cycle N.

## Test plan
- Reset then i_fetchReady=1 constant, no events: o_fetchAddr sequence 0x0, 0x4, 0x8, 0xC, with first valid one cycle after reset release.
- PC=0x10, redirect pc=0x08, imm=0x20, JALR=0: next o_fetchAddr=0x28, o_aluOp=2'b01 during the redirect cycle.
- JALR reg=0x1001, imm=0x3: target 0x1004 (bit0 cleared). Then reg=0x1000, imm=0x2: o_misaligned pulse, PC continues sequentially.
- Ready held low 3 cycles at addr 0x40 with redirect to 0x80 in cycle 2: o_fetchAddr stays 0x40 while valid; after handshake next address is 0x80.
- Trap and redirect in the same cycle, and redirect then trap during HOLD: PC = TRAP_VECTOR (0x100) in both cases.
- i_reset asserted during HOLD: o_fetchValid=0 next cycle, o_fetchAddr=RESET_VECTOR, pending event discarded.
